shading_pipe: RTL and testbench
===============================

SHADING_PIPE -- requirements
Module: shading_pipe

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the fixed-point word width of all vector components and intermediate values.
REQ-002 The block SHALL have parameter FRAC_BITS, default 24, meaning the number of fractional bits of every fixed-point operand.
REQ-003 The block SHALL have parameter CHAN_BITS, default 8, meaning the width of each output colour channel.
REQ-004 The block SHALL have parameter MISS_RGB, default {0,0,all ones}, meaning the 3*CHAN_BITS colour emitted for a miss.
REQ-005 The block SHALL have parameters AMB_R/G/B, default 0.2/0.3/0.4, and DIFF_R/G/B, default 0.8/0.7/0.5, all expressed in FRAC_BITS format.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port valid_in, input, 1 bit: the upstream pixel is valid.
REQ-009 The block SHALL have port ready_in, output, 1 bit: the block accepts a pixel this cycle.
REQ-010 The block SHALL have port hit_in, input, 1 bit: the ray hit geometry.
REQ-011 The block SHALL have ports normal_vec and light_vec, input, each 3*DATA_WIDTH bits: the unit normal and unit light direction.
REQ-012 The block SHALL have port depth_in, input, DATA_WIDTH bits: the hit distance, used only when SHADING_FADE_EN is defined.
REQ-013 The block SHALL have port shade_out, output, 3*CHAN_BITS bits, packed {R,G,B}.
REQ-014 The block SHALL have port valid_out, output, 1 bit: shade_out holds a pixel.
REQ-015 The block SHALL have port ready_out, input, 1 bit: downstream accepts the pixel.
REQ-016 The block SHALL have ports pix_count and hit_count, output, 32 bits each: the number of pixels delivered and the number of those that were hits.

Function
REQ-017 The pipeline SHALL have 4 stages, so that latency from acceptance to valid_out is 4 cycles with no stall: S1 dot(n,l) and amb_comp = max(n.y,0); S2 diffuse = max(dot,0) and ambient = 0.5 + 0.5*amb_comp; S3 per-channel ambient*AMB_x and diffuse*DIFF_x; S4 sum plus saturate.
REQ-018 Every stage SHALL advance only on adv = !valid_out || ready_out, and ready_in SHALL equal adv.
REQ-019 A transfer SHALL occur on valid_in && ready_in at input and on valid_out && ready_out at output.
REQ-020 While adv is low, every stage register, including valid and hit flags, SHALL hold its value, and shade_out SHALL stay stable while valid_out && !ready_out.
REQ-021 Bubbles (valid_in low on an accepted cycle) SHALL propagate as valid=0; only valid pixels SHALL reach the output.
REQ-022 Fixed-point multiplies SHALL form the full 2*DATA_WIDTH product and take bits [FRAC_BITS+DATA_WIDTH-1:FRAC_BITS], truncating toward negative infinity.
REQ-023 S4 SHALL saturate each channel: a negative sum gives 0; a sum >= 1.0 gives all ones; otherwise the output is bits [FRAC_BITS-1:FRAC_BITS-CHAN_BITS].
REQ-024 A miss pixel SHALL output MISS_RGB regardless of vector inputs.
REQ-025 pix_count SHALL increment on each output transfer, and hit_count SHALL increment on each output transfer of a hit.
REQ-026 Both counters SHALL wrap modulo 2^32 without flagging.

Reset
REQ-027 When rst is high at a clock edge, all valid flags, pipeline data, shade_out, pix_count and hit_count SHALL be set to 0.
REQ-028 During reset, valid_out SHALL be 0 and ready_in SHALL be 1.
REQ-029 Reset mid-stream SHALL discard all in-flight pixels, and those pixels SHALL NOT be counted.

Configuration
REQ-030 When macro SHADING_FADE_EN is defined, a stage S5 SHALL multiply each saturated-domain channel sum by fade = clamp(1.0 - depth_in*FADE_K, 0, 1.0), with FADE_K a parameter defaulting to 1/16.
REQ-031 With SHADING_FADE_EN defined, depth SHALL be carried alongside its pixel, latency SHALL be 5, and misses SHALL remain MISS_RGB.
REQ-032 When SHADING_FADE_EN is not defined, S5 SHALL NOT exist, depth_in SHALL be ignored, and latency SHALL be 4.

Verification
REQ-033 Scenario: hit, n=(0,1,0), l=(0,1,0), ready_out=1 -> after 4 cycles shade_out = {0xFF,0xFF,0xE6}, with R and G saturated.
REQ-034 Scenario: hit, n=(0,1,0), l=(0,-1,0) -> shade_out = {0x33,0x4C,0x66}, ambient only.
REQ-035 Scenario: miss -> shade_out = {0x00,0x00,0xFF}, pix_count +1, hit_count unchanged.
REQ-036 Scenario: 8 back-to-back pixels with ready_out low for cycles 5-7 -> no pixel lost or duplicated, output held stable, ready_in low while stalled, order preserved.
REQ-037 Scenario: rst asserted for 1 cycle with 3 pixels in flight -> valid_out=0 next cycle, counters 0, no stale pixel emitted afterward.
REQ-038 Scenario: SHADING_FADE_EN defined, hit of REQ-034 with depth_in=8.0 -> output at 5 cycles = {0x19,0x26,0x33}.

Source files
------------

// File: rtl/shading_pipe.sv
// shading_pipe: Lambert diffuse plus sky-ambient shader, one pixel per cycle,
// valid/ready flow control with a single global advance enable.
// Vectors are packed {x,y,z}, x in the most significant word; colour is {R,G,B}.
// Optional feature macro SHADING_FADE_EN: adds a fifth stage that scales the
// colour by a depth fade factor; the default build has four stages and
// ignores depth_in.
module shading_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 24,
  parameter int CHAN_BITS  = 8,
  parameter logic [3*CHAN_BITS-1:0] MISS_RGB = {{(2*CHAN_BITS){1'b0}}, {CHAN_BITS{1'b1}}},
  parameter logic [DATA_WIDTH-1:0] AMB_R  = 32'h0033_3333,
  parameter logic [DATA_WIDTH-1:0] AMB_G  = 32'h004C_CCCC,
  parameter logic [DATA_WIDTH-1:0] AMB_B  = 32'h0066_6666,
  parameter logic [DATA_WIDTH-1:0] DIFF_R = 32'h00CC_CCCC,
  parameter logic [DATA_WIDTH-1:0] DIFF_G = 32'h00B3_3333,
  parameter logic [DATA_WIDTH-1:0] DIFF_B = 32'h0080_0000,
  parameter logic [DATA_WIDTH-1:0] FADE_K = 32'h0010_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic                    hit_in,
  input  logic [3*DATA_WIDTH-1:0] normal_vec,
  input  logic [3*DATA_WIDTH-1:0] light_vec,
  input  logic [DATA_WIDTH-1:0]   depth_in,
  output logic [3*CHAN_BITS-1:0]  shade_out,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [31:0]             pix_count,
  output logic [31:0]             hit_count
);

  localparam logic [DATA_WIDTH-1:0] FX_ONE  = {{(DATA_WIDTH-FRAC_BITS-1){1'b0}}, 1'b1, {FRAC_BITS{1'b0}}};
  localparam logic [DATA_WIDTH-1:0] FX_HALF = FX_ONE >> 1;
  localparam logic [DATA_WIDTH-1:0] AMB_K  [3] = '{AMB_R, AMB_G, AMB_B};
  localparam logic [DATA_WIDTH-1:0] DIFF_K [3] = '{DIFF_R, DIFF_G, DIFF_B};

  // Signed fixed-point multiply: full-width product, middle word kept, so the
  // discarded fraction always rounds toward negative infinity.
  function automatic logic [DATA_WIDTH-1:0] fxmul(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
    return DATA_WIDTH'(({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a} *
                        {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b}) >> FRAC_BITS);
  endfunction

  // One guard bit so that the ambient + diffuse sum cannot wrap.
  function automatic logic [DATA_WIDTH:0] add_ext(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
    return {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
  endfunction

  function automatic logic [CHAN_BITS-1:0] sat_chan(input logic [DATA_WIDTH:0] s);
    if (s[DATA_WIDTH])
      return '0;
    else if (s >= {1'b0, FX_ONE})
      return '1;
    else
      return s[FRAC_BITS-1 -: CHAN_BITS];
  endfunction

  logic adv;
  logic out_valid;
  logic out_hit;
  logic [3*CHAN_BITS-1:0] out_shade;

  assign valid_out = out_valid && !rst;
  assign adv       = !valid_out || ready_out;
  assign ready_in  = adv;
  assign shade_out = out_shade;

  logic [DATA_WIDTH-1:0] n_x, n_y, n_z, l_x, l_y, l_z;
  logic [DATA_WIDTH-1:0] dot_c;

  assign n_x = normal_vec[3*DATA_WIDTH-1 -: DATA_WIDTH];
  assign n_y = normal_vec[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign n_z = normal_vec[DATA_WIDTH-1:0];
  assign l_x = light_vec[3*DATA_WIDTH-1 -: DATA_WIDTH];
  assign l_y = light_vec[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign l_z = light_vec[DATA_WIDTH-1:0];
  assign dot_c = fxmul(n_x, l_x) + fxmul(n_y, l_y) + fxmul(n_z, l_z);

  logic                  s1_valid, s1_hit;
  logic [DATA_WIDTH-1:0] s1_dot, s1_amb_comp;

  // S1: dot(n,l) and the upward-facing part of the normal for the sky term
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_hit      <= 1'b0;
      s1_dot      <= '0;
      s1_amb_comp <= '0;
    end else if (adv) begin
      s1_valid    <= valid_in;
      s1_hit      <= hit_in;
      s1_dot      <= dot_c;
      s1_amb_comp <= n_y[DATA_WIDTH-1] ? '0 : n_y;
    end
  end

  logic                  s2_valid, s2_hit;
  logic [DATA_WIDTH-1:0] s2_diffuse, s2_ambient;

  // S2: clamp back-facing light to zero, map sky term into [0.5, 1.0]
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      s2_hit     <= 1'b0;
      s2_diffuse <= '0;
      s2_ambient <= '0;
    end else if (adv) begin
      s2_valid   <= s1_valid;
      s2_hit     <= s1_hit;
      s2_diffuse <= s1_dot[DATA_WIDTH-1] ? '0 : s1_dot;
      s2_ambient <= FX_HALF + fxmul(FX_HALF, s1_amb_comp);
    end
  end

  logic                  s3_valid, s3_hit;
  logic [DATA_WIDTH-1:0] s3_amb  [3];
  logic [DATA_WIDTH-1:0] s3_diff [3];

  // S3: per-channel material weighting of both lighting terms
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid <= 1'b0;
      s3_hit   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        s3_amb[i]  <= '0;
        s3_diff[i] <= '0;
      end
    end else if (adv) begin
      s3_valid <= s2_valid;
      s3_hit   <= s2_hit;
      for (int i = 0; i < 3; i++) begin
        s3_amb[i]  <= fxmul(s2_ambient, AMB_K[i]);
        s3_diff[i] <= fxmul(s2_diffuse, DIFF_K[i]);
      end
    end
  end

  logic [DATA_WIDTH:0] sum_c [3];

  // S4 combinational: channel sums with guard bit
  always_comb begin
    for (int i = 0; i < 3; i++) sum_c[i] = add_ext(s3_amb[i], s3_diff[i]);
  end

`ifdef SHADING_FADE_EN
  logic [DATA_WIDTH-1:0] s1_depth, s2_depth, s3_depth;

  // Depth rides alongside its pixel through S1..S3
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_depth <= '0;
      s2_depth <= '0;
      s3_depth <= '0;
    end else if (adv) begin
      s1_depth <= depth_in;
      s2_depth <= s1_depth;
      s3_depth <= s2_depth;
    end
  end

  // Clamp into [0, 1.0) so the fade multiply cannot push a channel past full scale.
  function automatic logic [DATA_WIDTH-1:0] clamp_col(input logic [DATA_WIDTH:0] s);
    if (s[DATA_WIDTH])
      return '0;
    else if (s >= {1'b0, FX_ONE})
      return FX_ONE - 1'b1;
    else
      return s[DATA_WIDTH-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] fade_of(input logic [DATA_WIDTH-1:0] depth);
    logic [DATA_WIDTH-1:0] fk;
    logic [DATA_WIDTH:0]   f;
    fk = fxmul(depth, FADE_K);
    f  = {1'b0, FX_ONE} - {fk[DATA_WIDTH-1], fk};
    if (f[DATA_WIDTH])
      return '0;
    else if (f > {1'b0, FX_ONE})
      return FX_ONE;
    else
      return f[DATA_WIDTH-1:0];
  endfunction

  logic                  s4_valid, s4_hit;
  logic [DATA_WIDTH-1:0] s4_col [3];
  logic [DATA_WIDTH-1:0] s4_fade;

  // S4: saturated-domain channel sums and the fade factor for this depth
  always_ff @(posedge clk) begin
    if (rst) begin
      s4_valid <= 1'b0;
      s4_hit   <= 1'b0;
      s4_fade  <= '0;
      for (int i = 0; i < 3; i++) s4_col[i] <= '0;
    end else if (adv) begin
      s4_valid <= s3_valid;
      s4_hit   <= s3_hit;
      s4_fade  <= fade_of(s3_depth);
      for (int i = 0; i < 3; i++) s4_col[i] <= clamp_col(sum_c[i]);
    end
  end

  // S5: apply fade and quantise; misses bypass shading entirely
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_shade <= '0;
    end else if (adv) begin
      out_valid <= s4_valid;
      out_hit   <= s4_hit;
      out_shade <= s4_hit ? {sat_chan({1'b0, fxmul(s4_col[0], s4_fade)}),
                             sat_chan({1'b0, fxmul(s4_col[1], s4_fade)}),
                             sat_chan({1'b0, fxmul(s4_col[2], s4_fade)})}
                          : MISS_RGB;
    end
  end
`else
  logic unused_fade;
  assign unused_fade = ^{depth_in, FADE_K};

  // S4: saturate and quantise; misses bypass shading entirely
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_shade <= '0;
    end else if (adv) begin
      out_valid <= s3_valid;
      out_hit   <= s3_hit;
      out_shade <= s3_hit ? {sat_chan(sum_c[0]), sat_chan(sum_c[1]), sat_chan(sum_c[2])}
                          : MISS_RGB;
    end
  end
`endif

  // Delivered-pixel statistics, free-running modulo 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_count <= '0;
      hit_count <= '0;
    end else if (valid_out && ready_out) begin
      pix_count <= pix_count + 32'd1;
      if (out_hit) hit_count <= hit_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_shading_pipe.sv
// Scoreboard bench for shading_pipe: directed vectors with hand-computed colours.
`timescale 1ns/1ps
module tb_shading_pipe;
  localparam logic [31:0] ZERO = 32'h0000_0000;
  localparam logic [31:0] ONE  = 32'h0100_0000;
  localparam logic [31:0] NEG1 = 32'hFF00_0000;
  localparam logic [31:0] HALF = 32'h0080_0000;
  localparam logic [31:0] TWO  = 32'h0200_0000;
`ifdef SHADING_FADE_EN
  localparam int EXP_LAT = 5;
  localparam logic [23:0] D8_SHADE  = 24'h192633;
  localparam logic [23:0] D16_SHADE = 24'h000000;
`else
  localparam int EXP_LAT = 4;
  localparam logic [23:0] D8_SHADE  = 24'h334C66;
  localparam logic [23:0] D16_SHADE = 24'h334C66;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic        ready_in;
  logic        hit_in = 1'b0;
  logic [95:0] normal_vec = '0;
  logic [95:0] light_vec = '0;
  logic [31:0] depth_in = '0;
  logic [23:0] shade_out;
  logic        valid_out;
  logic        ready_out = 1'b1;
  logic [31:0] pix_count;
  logic [31:0] hit_count;

  shading_pipe dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in),
    .hit_in(hit_in), .normal_vec(normal_vec), .light_vec(light_vec),
    .depth_in(depth_in), .shade_out(shade_out), .valid_out(valid_out),
    .ready_out(ready_out), .pix_count(pix_count), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic [95:0] n;
    logic [95:0] l;
    logic [31:0] depth;
    logic [23:0] shade;
  } vec_t;

  typedef struct {
    logic        hit;
    logic [23:0] shade;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_pix = 0;
  int   model_hit = 0;

  function automatic vec_t mk(input logic hit, input logic [31:0] nx, ny, nz,
                              input logic [31:0] lx, ly, lz,
                              input logic [31:0] depth, input logic [23:0] shade);
    vec_t v;
    v.hit = hit;
    v.n = {nx, ny, nz};
    v.l = {lx, ly, lz};
    v.depth = depth;
    v.shade = shade;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic apply(input vec_t v);
    hit_in = v.hit;
    normal_vec = v.n;
    light_vec = v.l;
    depth_in = v.depth;
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.hit = v.hit;
    e.shade = v.shade;
    exp_q.push_back(e);
  endtask

  // Monitor: scoreboard compare on every output transfer, hold checks while stalled
  exp_t        mon_e;
  logic        prev_stall = 1'b0;
  logic [23:0] prev_shade = '0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_pix = 0;
      model_hit = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (valid_out !== 1'b1 || shade_out !== prev_shade) begin
          errors++;
          $display("FAIL hold: valid_out %b shade_out %06h, required 1 %06h",
                   valid_out, shade_out, prev_shade);
        end
      end
      if (valid_out && !ready_out) begin
        checks++;
        if (ready_in !== 1'b0) begin
          errors++;
          $display("FAIL ready_in_stall: got %b, required 0", ready_in);
        end
      end
      if (valid_out && ready_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel: got %06h, required no output", shade_out);
        end else begin
          mon_e = exp_q.pop_front();
          if (shade_out !== mon_e.shade) begin
            errors++;
            $display("FAIL shade_out: got %06h, required %06h", shade_out, mon_e.shade);
          end
          checks++;
          if (pix_count !== 32'(model_pix) || hit_count !== 32'(model_hit)) begin
            errors++;
            $display("FAIL counters: got pix %0d hit %0d, required pix %0d hit %0d",
                     pix_count, hit_count, model_pix, model_hit);
          end
          model_pix++;
          if (mon_e.hit) model_hit++;
        end
      end
      prev_stall = valid_out && !ready_out;
      prev_shade = shade_out;
    end
  end

  // Drive vecs[first..first+count-1]; optional bubbles, ready_out low in [stall_lo, stall_hi]
  task automatic run_stream(input int first, input int count, input int stall_lo,
                            input int stall_hi, input bit bubbles);
    int idx = first;
    int c = 0;
    bit bub;
    while (idx < first + count && c < 200) begin
      bub = bubbles && (c % 3 == 2);
      if (bub) begin
        apply(vecs[0]);
        valid_in = 1'b0;
      end else begin
        apply(vecs[idx]);
        valid_in = 1'b1;
      end
      ready_out = !(c >= stall_lo && c <= stall_hi);
      @(negedge clk);
      if (valid_in && ready_in) begin
        push_exp(vecs[idx]);
        idx++;
      end
      @(posedge clk);
      #1;
      c++;
    end
    valid_in = 1'b0;
    ready_out = 1'b1;
    check("stream_issue_budget", 32'(idx - first), 32'(count));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_outstanding", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    vecs.push_back(mk(1'b1, ZERO, ONE, ZERO, ZERO, ONE, ZERO, ZERO, 24'hFFFFE6));  // 0
    vecs.push_back(mk(1'b1, ZERO, ONE, ZERO, ZERO, NEG1, ZERO, ZERO, 24'h334C66)); // 1
    vecs.push_back(mk(1'b0, ZERO, ONE, ZERO, ZERO, ONE, ZERO, ZERO, 24'h0000FF));  // 2
    vecs.push_back(mk(1'b1, ZERO, NEG1, ZERO, ZERO, ONE, ZERO, ZERO, 24'h192633)); // 3
    vecs.push_back(mk(1'b1, ONE, ZERO, ZERO, HALF, ZERO, ZERO, ZERO, 24'h7F7F73)); // 4
    vecs.push_back(mk(1'b1, ZERO, HALF, ZERO, ZERO, NEG1, ZERO, ZERO, 24'h26394C)); // 5
    vecs.push_back(mk(1'b1, ZERO, TWO, ZERO, ZERO, ONE, ZERO, ZERO, 24'hFFFFFF));  // 6
    vecs.push_back(mk(1'b0, ONE, ZERO, ZERO, NEG1, ZERO, ZERO, ZERO, 24'h0000FF)); // 7
    vecs.push_back(mk(1'b1, ZERO, ZERO, ONE, ZERO, ZERO, ONE, ZERO, 24'hE6D9B3));  // 8
    vecs.push_back(mk(1'b1, ZERO, ONE, ZERO, ZERO, NEG1, ZERO, 32'h0800_0000, D8_SHADE));  // 9
    vecs.push_back(mk(1'b1, ZERO, ONE, ZERO, ZERO, NEG1, ZERO, 32'h1000_0000, D16_SHADE)); // 10
    vecs.push_back(mk(1'b0, ZERO, ONE, ZERO, ZERO, NEG1, ZERO, 32'h0800_0000, 24'h0000FF)); // 11

    // Reset behaviour
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid_out", {31'b0, valid_out}, 32'd0);
    check("rst_ready_in", {31'b0, ready_in}, 32'd1);
    check("rst_pix_count", pix_count, 32'd0);
    check("rst_hit_count", hit_count, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid_out", {31'b0, valid_out}, 32'd0);
    check("post_rst_shade_out", {8'b0, shade_out}, 32'd0);
    @(posedge clk);
    #1;

    // Single pixel latency
    apply(vecs[0]);
    valid_in = 1'b1;
    ready_out = 1'b1;
    @(negedge clk);
    check("idle_ready_in", {31'b0, ready_in}, 32'd1);
    push_exp(vecs[0]);
    @(posedge clk);
    #1 valid_in = 1'b0;
    lat = 1;
    seen = 1'b0;
    while (!seen && lat <= 20) begin
      @(negedge clk);
      if (valid_out) seen = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    @(posedge clk);
    #1;
    check("latency", 32'(lat), 32'(EXP_LAT));
    drain();

    // Mixed hits/misses with bubbles
    run_stream(1, 8, -1, -1, 1'b1);
    drain();

    // Back-to-back with downstream stall in cycles 5..7
    run_stream(0, 8, 5, 7, 1'b0);
    drain();

    // Depth-dependent vectors
    run_stream(9, 3, -1, -1, 1'b0);
    drain();

    // Reset with three pixels in flight
    run_stream(0, 3, -1, -1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid_out", {31'b0, valid_out}, 32'd0);
    check("midrst_ready_in", {31'b0, ready_in}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("after_midrst_valid_out", {31'b0, valid_out}, 32'd0);
    check("after_midrst_pix_count", pix_count, 32'd0);
    check("after_midrst_hit_count", hit_count, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    run_stream(3, 1, -1, -1, 1'b0);
    drain();
    check("final_pix_count", pix_count, 32'd1);
    check("final_hit_count", hit_count, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
